// File: rtl/register_scoreboard.sv
// Issue scoreboard between decode and execute: counts in-flight writes per
// architectural register and holds decode on RAW, WAW-saturation or capacity hazards.
module register_scoreboard #(
   parameter int NUM_REGISTERS           = 32,
   parameter int MAX_PENDING             = 3,
   parameter int MAX_IN_FLIGHT           = 8,
   parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   issue_done_in,
   output logic                                   issue_stall_out,
   input  logic [REGISTER_INDEXING_WIDTH-1:0]     read_register_1_in,
   input  logic                                   read_register_1_valid_in,
   input  logic [REGISTER_INDEXING_WIDTH-1:0]     read_register_2_in,
   input  logic                                   read_register_2_valid_in,
   input  logic [REGISTER_INDEXING_WIDTH-1:0]     write_register_in,
   input  logic                                   write_register_valid_in,
   output logic                                   execute_done_out,
   input  logic                                   execute_stall_in,
   input  logic                                   retire_valid_in,
   input  logic [REGISTER_INDEXING_WIDTH-1:0]     retire_register_in,
   input  logic                                   flush_in,
   output logic [NUM_REGISTERS-1:0]               pending_mask_out,
   output logic [$clog2(MAX_IN_FLIGHT+1)-1:0]     in_flight_count_out,
   output logic                                   retire_error_out
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);
   localparam int TOT_W = $clog2(MAX_IN_FLIGHT + 1);
   localparam int RIW   = REGISTER_INDEXING_WIDTH;

   logic [CNT_W-1:0] count [NUM_REGISTERS];
   logic [TOT_W-1:0] total;
   logic             retire_error;

   logic rs1_nz, rs2_nz, rd_nz, rr_nz;
   logic hazard_1, hazard_2, waw_full, total_full, blocked;
   logic transfer, inc, retire_hit, retire_err;

   // Hazard detection looks only at registered counts, so a same-cycle retire never unblocks.
   always_comb begin
      rs1_nz     = read_register_1_in != '0;
      rs2_nz     = read_register_2_in != '0;
      rd_nz      = write_register_in != '0;
      rr_nz      = retire_register_in != '0;
      hazard_1   = read_register_1_valid_in && rs1_nz && (count[read_register_1_in] != '0);
      hazard_2   = read_register_2_valid_in && rs2_nz && (count[read_register_2_in] != '0);
      waw_full   = write_register_valid_in && rd_nz &&
                   (count[write_register_in] == CNT_W'(MAX_PENDING));
      total_full = (total == TOT_W'(MAX_IN_FLIGHT)) && write_register_valid_in && rd_nz;
      blocked    = hazard_1 || hazard_2 || waw_full || total_full || flush_in;
   end

   always_comb begin
      execute_done_out = !rst && issue_done_in && !blocked;
      issue_stall_out  = rst || blocked || execute_stall_in;
      transfer         = execute_done_out && !execute_stall_in;
      inc              = transfer && write_register_valid_in && rd_nz;
      retire_hit       = retire_valid_in && rr_nz && !flush_in &&
                         (count[retire_register_in] != '0);
      retire_err       = retire_valid_in && rr_nz && !flush_in &&
                         (count[retire_register_in] == '0);
   end

   // An issue and a retire hitting the same register cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            count[i] <= '0;
         end
         total        <= '0;
         retire_error <= 1'b0;
      end else if (flush_in) begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            count[i] <= '0;
         end
         total <= '0;
      end else begin
         for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (inc && (write_register_in == RIW'(i)) &&
                !(retire_hit && (retire_register_in == RIW'(i)))) begin
               count[i] <= count[i] + CNT_W'(1);
            end else if (retire_hit && (retire_register_in == RIW'(i)) &&
                         !(inc && (write_register_in == RIW'(i)))) begin
               count[i] <= count[i] - CNT_W'(1);
            end
         end
         if (inc && !retire_hit) begin
            total <= total + TOT_W'(1);
         end else if (retire_hit && !inc) begin
            total <= total - TOT_W'(1);
         end
         if (retire_err) begin
            retire_error <= 1'b1;
         end
      end
   end

   always_comb begin
      pending_mask_out = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         pending_mask_out[i] = count[i] != '0;
      end
      in_flight_count_out = total;
      retire_error_out    = retire_error;
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// Scoreboard bench for register_scoreboard: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_scoreboard;

   logic        clk;
   logic        rst;
   logic        issue_done_in;
   logic        issue_stall_out;
   logic [4:0]  read_register_1_in;
   logic        read_register_1_valid_in;
   logic [4:0]  read_register_2_in;
   logic        read_register_2_valid_in;
   logic [4:0]  write_register_in;
   logic        write_register_valid_in;
   logic        execute_done_out;
   logic        execute_stall_in;
   logic        retire_valid_in;
   logic [4:0]  retire_register_in;
   logic        flush_in;
   logic [31:0] pending_mask_out;
   logic [3:0]  in_flight_count_out;
   logic        retire_error_out;

   register_scoreboard dut (
      .clk                      (clk),
      .rst                      (rst),
      .issue_done_in            (issue_done_in),
      .issue_stall_out          (issue_stall_out),
      .read_register_1_in       (read_register_1_in),
      .read_register_1_valid_in (read_register_1_valid_in),
      .read_register_2_in       (read_register_2_in),
      .read_register_2_valid_in (read_register_2_valid_in),
      .write_register_in        (write_register_in),
      .write_register_valid_in  (write_register_valid_in),
      .execute_done_out         (execute_done_out),
      .execute_stall_in         (execute_stall_in),
      .retire_valid_in          (retire_valid_in),
      .retire_register_in       (retire_register_in),
      .flush_in                 (flush_in),
      .pending_mask_out         (pending_mask_out),
      .in_flight_count_out      (in_flight_count_out),
      .retire_error_out         (retire_error_out)
   );

   typedef struct {
      string       name;
      logic [31:0] done;
      logic [31:0] stall;
      logic [31:0] mask;
      logic [31:0] infl;
      logic [31:0] err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(e.name, "done",  32'(execute_done_out),    e.done);
         chk(e.name, "stall", 32'(issue_stall_out),     e.stall);
         chk(e.name, "mask",  pending_mask_out,         e.mask);
         chk(e.name, "infl",  32'(in_flight_count_out), e.infl);
         chk(e.name, "err",   32'(retire_error_out),    e.err);
      end
   end

   task automatic push(input string nm, input logic [31:0] d, input logic [31:0] s,
                       input logic [31:0] m, input logic [31:0] c, input logic [31:0] er);
      exp_t x;
      x.name = nm; x.done = d; x.stall = s; x.mask = m; x.infl = c; x.err = er;
      q.push_back(x);
   endtask

   task automatic clr();
      issue_done_in            = 1'b0;
      read_register_1_in       = 5'd0;
      read_register_1_valid_in = 1'b0;
      read_register_2_in       = 5'd0;
      read_register_2_valid_in = 1'b0;
      write_register_in        = 5'd0;
      write_register_valid_in  = 1'b0;
      execute_stall_in         = 1'b0;
      retire_valid_in          = 1'b0;
      retire_register_in       = 5'd0;
      flush_in                 = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      clr();
      issue_done_in           = 1'b1;
      write_register_valid_in = 1'b1;
      write_register_in       = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clr();
      tick();
      push("rst_hold", 0, 1, 0, 0, 0);
      tick();
      rst = 1'b0;

      // build count[5]=2, then reset asynchronously mid-operation
      issue(5'd5); push("pre_rst_a", 1, 0, 0, 0, 0); tick();
      issue(5'd5); push("pre_rst_b", 1, 0, 32'h20, 1, 0); tick();
      clr();       push("pre_rst_idle", 0, 0, 32'h20, 2, 0); tick();
      #2;
      rst = 1'b1;
      push("rst_async", 0, 1, 0, 0, 0); tick();
      rst = 1'b0;
      issue(5'd0); push("rd0_issue", 1, 0, 0, 0, 0); tick();
      clr();       push("rd0_nocount", 0, 0, 0, 0, 0); tick();

      // RAW on rs1 with retire release one cycle later
      issue(5'd5); push("raw_wr", 1, 0, 0, 0, 0); tick();
      clr(); issue_done_in = 1'b1; read_register_1_valid_in = 1'b1; read_register_1_in = 5'd5;
      push("raw_stall", 0, 1, 32'h20, 1, 0); tick();
      retire_valid_in = 1'b1; retire_register_in = 5'd5;
      push("raw_retire_N", 0, 1, 32'h20, 1, 0); tick();
      retire_valid_in = 1'b0;
      push("raw_release_N1", 1, 0, 0, 0, 0); tick();

      // RAW on rs2; an unused rs2 with the same index is not a hazard
      issue(5'd6); push("rs2_wr", 1, 0, 0, 0, 0); tick();
      clr(); issue_done_in = 1'b1; read_register_2_valid_in = 1'b1; read_register_2_in = 5'd6;
      push("rs2_stall", 0, 1, 32'h40, 1, 0); tick();
      read_register_2_valid_in = 1'b0;
      push("rs2_unused", 1, 0, 32'h40, 1, 0); tick();
      clr(); retire_valid_in = 1'b1; retire_register_in = 5'd6;
      push("rs2_retire", 0, 0, 32'h40, 1, 0); tick();

      // WAW saturation at MAX_PENDING=3
      issue(5'd7); push("waw_1", 1, 0, 0, 0, 0); tick();
      issue(5'd7); push("waw_2", 1, 0, 32'h80, 1, 0); tick();
      issue(5'd7); push("waw_3", 1, 0, 32'h80, 2, 0); tick();
      issue(5'd7); push("waw_full", 0, 1, 32'h80, 3, 0); tick();
      retire_valid_in = 1'b1; retire_register_in = 5'd7;
      push("waw_full_retire", 0, 1, 32'h80, 3, 0); tick();
      issue(5'd7); push("waw_accept", 1, 0, 32'h80, 2, 0); tick();
      for (int k = 0; k < 3; k++) begin
         clr(); retire_valid_in = 1'b1; retire_register_in = 5'd7;
         push("waw_drain", 0, 0, 32'h80, 32'(3 - k), 0); tick();
      end

      // total in-flight limit of 8
      for (int k = 1; k <= 8; k++) begin
         issue(5'(k));
         push("total_fill", 1, 0, (32'd1 << k) - 32'd2, 32'(k - 1), 0); tick();
      end
      issue(5'd9); push("total_full", 0, 1, 32'h1FE, 8, 0); tick();
      write_register_valid_in = 1'b0;
      push("total_nowrite", 1, 0, 32'h1FE, 8, 0); tick();
      issue(5'd0); push("total_rd0", 1, 0, 32'h1FE, 8, 0); tick();
      for (int k = 1; k <= 8; k++) begin
         clr(); retire_valid_in = 1'b1; retire_register_in = 5'(k);
         push("total_drain", 0, 0, 32'h1FE - ((32'd1 << k) - 32'd2), 32'(9 - k), 0); tick();
      end

      // backpressure and simultaneous events
      issue(5'd3); execute_stall_in = 1'b1;
      push("bp_hold", 1, 1, 0, 0, 0); tick();
      clr();       push("bp_nochg", 0, 0, 0, 0, 0); tick();
      issue(5'd3); push("bp_go", 1, 0, 0, 0, 0); tick();
      issue(5'd3); retire_valid_in = 1'b1; retire_register_in = 5'd3;
      push("same_reg", 1, 0, 32'h8, 1, 0); tick();
      clr(); retire_valid_in = 1'b1; retire_register_in = 5'd0;
      push("same_after", 0, 0, 32'h8, 1, 0); tick();
      issue(5'd10); retire_valid_in = 1'b1; retire_register_in = 5'd3;
      push("diff_reg", 1, 0, 32'h8, 1, 0); tick();
      clr(); push("diff_after", 0, 0, 32'h400, 1, 0); tick();
      retire_valid_in = 1'b1; retire_register_in = 5'd10;
      push("diff_ret", 0, 0, 32'h400, 1, 0); tick();
      clr(); push("diff_empty", 0, 0, 0, 0, 0); tick();

      // flush with concurrent retire, then sticky retire error
      issue(5'd2); push("fl_setup_a", 1, 0, 0, 0, 0); tick();
      issue(5'd4); push("fl_setup_b", 1, 0, 32'h4, 1, 0); tick();
      issue(5'd4); push("fl_setup_c", 1, 0, 32'h14, 2, 0); tick();
      issue(5'd9); flush_in = 1'b1; retire_valid_in = 1'b1; retire_register_in = 5'd2;
      push("flush", 0, 1, 32'h14, 3, 0); tick();
      clr(); push("post_flush", 0, 0, 0, 0, 0); tick();
      flush_in = 1'b1; retire_valid_in = 1'b1; retire_register_in = 5'd2;
      push("flush_ret0", 0, 1, 0, 0, 0); tick();
      clr(); retire_valid_in = 1'b1; retire_register_in = 5'd4;
      push("ret_err_cyc", 0, 0, 0, 0, 0); tick();
      clr(); push("err_set", 0, 0, 0, 0, 1); tick();
      issue(5'd0); push("err_sticky", 1, 0, 0, 0, 1); tick();
      clr(); rst = 1'b1;
      push("err_rst", 0, 1, 0, 0, 0); tick();
      rst = 1'b0;
      push("after_rst", 0, 0, 0, 0, 0); tick();

      tick();
      for (int i = 0; i < 5 && q.size() > 0; i++) tick();
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
Issue controller between the decode stage and the execute stage. It tracks how many writes are in flight to each architectural register. It holds an instruction at decode while any source register, or a saturated destination register, still has writes outstanding. It releases the instruction into execute using the same done/stall handshake the pipeline stages use, and it clears pending state on retirement (writeback) or flush.

Parameters:
NUM_REGISTERS, 32, architectural register count; register 0 is hardwired zero and is never pending.
MAX_PENDING, 3, maximum in-flight writes tracked per register.
MAX_IN_FLIGHT, 8, maximum total in-flight writes across all registers.
REGISTER_INDEXING_WIDTH, $clog2(NUM_REGISTERS), index width (derived).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
issue_done_in  input  1  decode has a valid instruction (prev_done).
issue_stall_out  output  1  holds decode (stall_prev).
read_register_1_in  input  REGISTER_INDEXING_WIDTH  rs1 index.
read_register_1_valid_in  input  1  rs1 is used.
read_register_2_in  input  REGISTER_INDEXING_WIDTH  rs2 index.
read_register_2_valid_in  input  1  rs2 is used.
write_register_in  input  REGISTER_INDEXING_WIDTH  rd index.
write_register_valid_in  input  1  instruction writes rd.
execute_done_out  output  1  instruction offered to execute (done_next).
execute_stall_in  input  1  execute cannot accept (next_stall).
retire_valid_in  input  1  writeback committed a register write.
retire_register_in  input  REGISTER_INDEXING_WIDTH  register written at writeback.
flush_in  input  1  discard all in-flight instructions.
pending_mask_out  output  NUM_REGISTERS  bit i = count[i] != 0.
in_flight_count_out  output  $clog2(MAX_IN_FLIGHT+1)  total outstanding writes.
retire_error_out  output  1  sticky: retire received for a register with count 0.

Behaviour:
- State: per-register counter count[i] (width $clog2(MAX_PENDING+1)), total counter, sticky error flag.
- Reset (asynchronous, rst=1): all counters 0, retire_error_out=0, pending_mask_out=0, in_flight_count_out=0.
- Combinational outputs while rst=1: execute_done_out=0 and issue_stall_out=1.
- hazard_1 = read_register_1_valid_in && read_register_1_in!=0 && count[rs1]!=0. hazard_2 is the same for rs2.
- waw_full = write_register_valid_in && write_register_in!=0 && count[rd]==MAX_PENDING.
- total_full = total==MAX_IN_FLIGHT && write_register_valid_in && write_register_in!=0.
- blocked = hazard_1 || hazard_2 || waw_full || total_full || flush_in.
- execute_done_out = !rst && issue_done_in && !blocked.
- issue_stall_out = rst || blocked || execute_stall_in. Both outputs are purely combinational, so there is zero added latency.
- Transfer occurs when execute_done_out && !execute_stall_in. If write_register_valid_in and rd!=0 at a transfer, count[rd]++ and total++ at the next edge.
- Hazard checks use registered counts only. A retire in cycle N does not unblock an issue in cycle N; the earliest release is cycle N+1.
- Retire: if retire_valid_in, retire_register_in!=0 and count!=0, then count-- and total--.
  - Retire to register 0 is ignored.
  - Retire to a register with count 0 is ignored and sets retire_error_out=1. The flag clears only on rst.
- Simultaneous transfer and retire to the same register: count unchanged, total unchanged. A saturated register may issue in that cycle only if waw_full was false, since the check uses the registered count.
- Simultaneous transfer and retire to different registers: both applied.
- Flush: at the next edge all counters go to 0. Issue is blocked that cycle, a retire in the same cycle is ignored, and the error flag is unaffected. Flush has priority over retire.
- Counters never wrap. Underflow is prevented by the error rule; overflow is prevented by waw_full and total_full.
- Transfer with write_register_valid_in=0, or with rd=0, changes no state.

Test Plan:
- Reset then idle: rst pulse mid-operation with count[5]=2 -> immediately pending_mask_out=0, in_flight_count_out=0, issue_stall_out=1. After release, issue of rd=0 with no sources -> execute_done_out=1 the same cycle and counts stay 0.
- RAW: transfer rd=5, then offer rs1=5 -> execute_done_out=0, issue_stall_out=1. Retire 5 in cycle N -> still stalled in N, execute_done_out=1 in N+1.
- WAW saturation: three transfers with rd=7 and no retire -> count 3, pending_mask_out[7]=1. Fourth rd=7 -> blocked until one retire, then accepted; in_flight_count_out returns to 3.
- Total limit: transfer rd=1..8 -> in_flight_count_out=8. rd=9 blocked, but an instruction with write_register_valid_in=0 and no hazards is still accepted.
- Backpressure plus simultaneous events: execute_stall_in=1 with a legal issue -> execute_done_out=1, issue_stall_out=1, no count change. Same-cycle transfer rd=3 and retire 3 (count 1) -> count stays 1.
- Flush and error: counts {2:1, 4:2}, flush with a concurrent retire 2 -> all counts 0 next cycle and retire_error_out=0. A later retire 4 -> retire_error_out=1 and it stays high until rst.
